md5_block_engine: RTL

Sequential, parametrised MD5 compression engine. Captures one 512-bit message block and a 128-bit chaining value, then runs all 64 MD5 steps across all four rounds (F, G, H, I) with internal T-constant and rotate tables. It performs UNROLL steps per clock and adds the result back into the chaining value. It sits between the message padder/scheduler and the digest register in the hashing datapath.

---
 rtl/md5_block_engine.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/md5_block_engine.sv
// md5_block_engine
// Runs the 64-step MD5 compression on one captured 512-bit block, UNROLL steps
// per clock, and adds the working state back into the captured chaining value.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      request to process a block (sampled only while idle)
//   block_in   X[0..15], X[k] = block_in[32k+31:32k]
//   chain_in   input chaining value {D,C,B,A}, A in [31:0]
//   busy       high from the accepting edge until the done edge
//   done       one-cycle pulse; chain_out is valid from this cycle on
//   chain_out  registered result {D,C,B,A}; holds until the next done
//
// Handshake: start is a request with no ready; it is accepted on an edge where
// the engine is idle (busy=0 before that edge) and rst is low. Requests seen
// while busy are dropped. Inputs are captured on the accepting edge only, so the
// source may change them freely afterwards.
module md5_block_engine #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic [127:0] chain_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] chain_out
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16))
  begin : g_bad_unroll
    $error("md5_block_engine: UNROLL must be one of 1, 2, 4, 8, 16");
  end

  localparam logic [6:0] STEP = 7'(UNROLL);

  // T[i] = floor(|sin(i+1)| * 2^32)
  localparam logic [31:0] T_TABLE [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Rotate amount for step i: row by round, column by i mod 4.
  function automatic logic [4:0] rot_amt(input logic [5:0] i);
    logic [4:0] s;
    s = 5'd0;
    case (i[5:4])
      2'd0: case (i[1:0]) 2'd0: s = 5'd7; 2'd1: s = 5'd12; 2'd2: s = 5'd17; default: s = 5'd22; endcase
      2'd1: case (i[1:0]) 2'd0: s = 5'd5; 2'd1: s = 5'd9;  2'd2: s = 5'd14; default: s = 5'd20; endcase
      2'd2: case (i[1:0]) 2'd0: s = 5'd4; 2'd1: s = 5'd11; 2'd2: s = 5'd16; default: s = 5'd23; endcase
      default: case (i[1:0]) 2'd0: s = 5'd6; 2'd1: s = 5'd10; 2'd2: s = 5'd15; default: s = 5'd21; endcase
    endcase
    return s;
  endfunction

  // One MD5 step on packed state {D,C,B,A}. Word indices are computed in
  // 4 bits, which is the mod-16 reduction.
  function automatic logic [127:0] md5_step(input logic [127:0] abcd,
                                            input logic [5:0]   i,
                                            input logic [511:0] x);
    logic [31:0] a, b, c, d, fn, sum, rot;
    logic [3:0]  k;
    logic [4:0]  s;
    {d, c, b, a} = abcd;
    fn = 32'd0;
    k  = 4'd0;
    case (i[5:4])
      2'd0: begin fn = (b & c) | (~b & d); k = i[3:0];                end
      2'd1: begin fn = (b & d) | (c & ~d); k = i[3:0] * 4'd5 + 4'd1;  end
      2'd2: begin fn = b ^ c ^ d;          k = i[3:0] * 4'd3 + 4'd5;  end
      default: begin fn = c ^ (b | ~d);    k = i[3:0] * 4'd7;         end
    endcase
    s   = rot_amt(i);
    sum = a + fn + x[{k, 5'd0} +: 32] + T_TABLE[i];
    // s is never 0, so the right shift amount stays within 1..31.
    rot = (sum << s) | (sum >> (6'd32 - {1'b0, s}));
    return {c, b, b + rot, d};
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, FINAL} state_t;

  state_t       state;
  logic [6:0]   cnt;
  logic [511:0] blk_q;
  logic [127:0] chain_q;
  logic [127:0] work_q;
  logic [127:0] work_next;

  // UNROLL steps chained combinationally within one cycle.
  always_comb begin
    work_next = work_q;
    for (int u = 0; u < UNROLL; u++) begin
      work_next = md5_step(work_next, cnt[5:0] + 6'(u), blk_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 7'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      chain_out <= 128'd0;
      blk_q     <= 512'd0;
      chain_q   <= 128'd0;
      work_q    <= 128'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            blk_q   <= block_in;
            chain_q <= chain_in;
            work_q  <= chain_in;
            cnt     <= 7'd0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          work_q <= work_next;
          cnt    <= cnt + STEP;
          if (cnt + STEP == 7'd64) state <= FINAL;
        end
        FINAL: begin
          chain_out <= {chain_q[127:96] + work_q[127:96],
                        chain_q[95:64]  + work_q[95:64],
                        chain_q[63:32]  + work_q[63:32],
                        chain_q[31:0]   + work_q[31:0]};
          done  <= 1'b1;
          busy  <= 1'b0;
          cnt   <= 7'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
